// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: access size codes, MMIO base,
// register offsets and error-flag bit positions.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        SizeByte = 2'b00,
        SizeHalf = 2'b01,
        SizeWord = 2'b10,
        SizeIll  = 2'b11
    } mem_size_e;

    // Timer register select, taken from offset bits 3:2.
    typedef enum logic [1:0] {
        TmrMtimeLo = 2'b00,
        TmrMtimeHi = 2'b01,
        TmrCmpLo   = 2'b10,
        TmrCmpHi   = 2'b11
    } timer_reg_e;

    localparam logic [3:0]  MmioBase      = 4'h1;

    localparam logic [27:0] OffMtimeLo    = 28'h000_0000;
    localparam logic [27:0] OffMtimeHi    = 28'h000_0004;
    localparam logic [27:0] OffMtimeCmpLo = 28'h000_0008;
    localparam logic [27:0] OffMtimeCmpHi = 28'h000_000C;
    localparam logic [27:0] OffGpio       = 28'h000_0010;
    localparam logic [27:0] OffErr        = 28'h000_0014;

    localparam int unsigned ErrMisalign   = 0;
    localparam int unsigned ErrIllegal    = 1;

endpackage

// File: rtl/mmio_timer.sv
// Memory-mapped 64-bit timer: prescaler, mtime, mtimecmp and a level timer_irq.
// Only instantiated when DATA_MEM_TIMER_EN is defined.
module mmio_timer
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned TIMER_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  sel,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        timer_irq
);

    localparam int unsigned PrescW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PrescW-1:0] PrescMax = PrescW'(TIMER_DIV - 1);

    timer_reg_e        reg_sel;
    logic [PrescW-1:0] presc_q, presc_d;
    logic [63:0]       mtime_q, mtime_d;
    logic [63:0]       mtimecmp_q, mtimecmp_d;
    logic              tick;

    assign reg_sel = timer_reg_e'(sel);
    assign tick    = (presc_q == PrescMax);

    // A software write to either mtime half takes priority over the increment;
    // the prescaler keeps running regardless.
    always_comb begin
        presc_d    = tick ? '0 : presc_q + 1'b1;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        if (wr_en) begin
            unique case (reg_sel)
                TmrMtimeLo: mtime_d    = {mtime_q[63:32], write_data};
                TmrMtimeHi: mtime_d    = {write_data, mtime_q[31:0]};
                TmrCmpLo:   mtimecmp_d = {mtimecmp_q[63:32], write_data};
                TmrCmpHi:   mtimecmp_d = {write_data, mtimecmp_q[31:0]};
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

    always_comb begin
        read_data = '0;
        unique case (reg_sel)
            TmrMtimeLo: read_data = mtime_q[31:0];
            TmrMtimeHi: read_data = mtime_q[63:32];
            TmrCmpLo:   read_data = mtimecmp_q[31:0];
            TmrCmpHi:   read_data = mtimecmp_q[63:32];
            default:    read_data = '0;
        endcase
    end

    assign timer_irq = (mtime_q >= mtimecmp_q);

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-addressable word RAM plus MMIO (timer, GPIO, sticky errors).
// Define DATA_MEM_TIMER_EN to include the timer; otherwise its offsets read 0 and irq is 0.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned TIMER_DIV = 1,
    parameter int unsigned GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [1:0]        mem_ctrl,
    input  logic [31:0]       addr,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              timer_irq,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              acc_err
);

    mem_size_e   size;
    logic        is_mmio;
    logic [27:0] off;
    logic        misalign;
    logic        illegal;
    logic        access_ok;
    logic        wr_ok;

    assign size      = mem_size_e'(mem_ctrl);
    assign is_mmio   = (addr[31:28] == MmioBase);
    assign off       = addr[27:0];
    assign illegal   = (size == SizeIll) || (is_mmio && (size != SizeWord));
    assign access_ok = !misalign && !illegal;
    assign wr_ok     = we && access_ok;

    always_comb begin
        misalign = 1'b0;
        unique case (size)
            SizeHalf: misalign = addr[0];
            SizeWord: misalign = |addr[1:0];
            default:  misalign = 1'b0;
        endcase
    end

    // ---------------- RAM ----------------
    logic [31:0]       ram [2**ADDR_W];
    logic [ADDR_W-1:0] ram_idx;
    logic [3:0]        lane_en;
    logic [31:0]       wdata_lanes;
    logic [31:0]       ram_word;
    logic [31:0]       ram_shift;
    logic [31:0]       ram_rdata;

    assign ram_idx     = addr[ADDR_W+1:2];
    assign wdata_lanes = write_data << {addr[1:0], 3'b000};
    assign ram_word    = ram[ram_idx];
    assign ram_shift   = ram_word >> {addr[1:0], 3'b000};

    always_comb begin
        lane_en   = 4'b0000;
        ram_rdata = '0;
        unique case (size)
            SizeByte: begin
                lane_en   = 4'b0001 << addr[1:0];
                ram_rdata = {24'b0, ram_shift[7:0]};
            end
            SizeHalf: begin
                lane_en   = 4'b0011 << addr[1:0];
                ram_rdata = {16'b0, ram_shift[15:0]};
            end
            SizeWord: begin
                lane_en   = 4'b1111;
                ram_rdata = ram_word;
            end
            default: ;
        endcase
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok && !is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    ram[ram_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                end
            end
        end
    end

    // ---------------- MMIO: GPIO and ERR ----------------
    logic [GPIO_W-1:0] gpio_q;
    logic [1:0]        err_q, err_d, err_set, err_clr;
    logic              gpio_wr, err_wr;

    assign gpio_wr = wr_ok && is_mmio && (off == OffGpio);
    assign err_wr  = wr_ok && is_mmio && (off == OffErr);

    // Set has priority over the write-1-to-clear in the same cycle.
    always_comb begin
        err_set              = 2'b00;
        err_set[ErrMisalign] = misalign;
        err_set[ErrIllegal]  = illegal;
        err_clr              = err_wr ? write_data[1:0] : 2'b00;
        err_d                = (err_q & ~err_clr) | err_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_q <= '0;
            err_q  <= '0;
        end else begin
            if (gpio_wr) begin
                gpio_q <= write_data[GPIO_W-1:0];
            end
            err_q <= err_d;
        end
    end

    assign gpio_out = gpio_q;
    assign acc_err  = |err_q;

    // ---------------- MMIO: timer ----------------
    logic [31:0] timer_rdata;

`ifdef DATA_MEM_TIMER_EN
    logic timer_sel;
    assign timer_sel = is_mmio && (off[27:4] == 24'h0);

    mmio_timer #(
        .TIMER_DIV (TIMER_DIV)
    ) u_mmio_timer (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_ok && timer_sel),
        .sel        (off[3:2]),
        .write_data (write_data),
        .read_data  (timer_rdata),
        .timer_irq  (timer_irq)
    );
`else
    logic unused_timer_div;
    assign unused_timer_div = ^TIMER_DIV;
    assign timer_rdata      = '0;
    assign timer_irq        = 1'b0;
`endif

    // ---------------- Read mux ----------------
    logic [31:0] mmio_rdata;

    always_comb begin
        mmio_rdata = '0;
        if (off == OffGpio) begin
            mmio_rdata = 32'(gpio_q);
        end else if (off == OffErr) begin
            mmio_rdata = {30'b0, err_q};
        end else if (off[27:4] == 24'h0) begin
            mmio_rdata = timer_rdata;
        end
    end

    always_comb begin
        read_data = '0;
        if (access_ok) begin
            read_data = is_mmio ? mmio_rdata : ram_rdata;
        end
    end

endmodule
